itlb_ptw_ctrl: RTL

- Sv32 page-table-walk sequencer for the instruction TLB.
- On an ITLB miss it accepts the miss VPN and issues up to two PTE reads over a single-outstanding memory read port.
- It applies the instruction-fetch permission checks and ends with either an ITLB refill pulse or a fault pulse.
- Sits between the ITLB control/tag logic and the shared memory-side read arbiter.

---
 rtl/mms_pkg.sv | 63 ++++++
 rtl/itlb_ptw_pte_check.sv | 17 +
 rtl/itlb_ptw_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mms_pkg.sv
// mms_pkg: types and helpers shared by the MMU walkers.
//   ptw_state_e  : walker sequencer states
//   pte_t/satp_t : Sv32 PTE and satp CSR layouts
//   pte_check()  : instruction-side PTE legality / leaf decode
package mms_pkg;

    localparam int MXLEN      = 32;
    localparam int SV32_VPN_W = 20;
    localparam int SV32_PPN_W = 22;
    localparam int SV32_PA_W  = 34;

    // Exception codes reported by fault_cause_o (0 -> IPF, 1 -> IAF)
    localparam int CAUSE_IPF = 12;
    localparam int CAUSE_IAF = 1;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L0_REQ,
        L0_WAIT,
        DRAIN,
        DONE
    } ptw_state_e;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef struct packed {
        logic                  mode;
        logic [8:0]            asid;
        logic [SV32_PPN_W-1:0] ppn;
    } satp_t;

    // Returns {leaf, fault}. U is not examined: privilege is checked at
    // ITLB lookup time, not during the walk.
    function automatic logic [1:0] pte_check(pte_t pte, logic is_l1);
        logic leaf;
        logic fault;
        leaf  = pte.r | pte.x;
        fault = ~pte.v | (~pte.r & pte.w);
        if (leaf) begin
            // fetch needs X and A; an L1 leaf must be 4 MiB aligned
            fault = fault | ~pte.x | ~pte.a | (is_l1 & (pte.ppn0 != '0));
        end else begin
            // pointer at the last level has nowhere to go
            fault = fault | ~is_l1;
        end
        return {leaf, fault};
    endfunction

endpackage

// File: rtl/itlb_ptw_pte_check.sv
// itlb_ptw_pte_check: combinational PTE decode for the instruction walker.
//   pte   : PTE word returned by memory
//   is_l1 : PTE came from the first-level table
//   leaf  : PTE is a leaf (R or X set)
//   fault : PTE is illegal for an instruction fetch at this level
module itlb_ptw_pte_check
    import mms_pkg::*;
(
    input  pte_t pte,
    input  logic is_l1,
    output logic leaf,
    output logic fault
);

    assign {leaf, fault} = pte_check(pte, is_l1);

endmodule

// File: rtl/itlb_ptw_ctrl.sv
// itlb_ptw_ctrl: Sv32 page-table walker for the instruction TLB.
//   clk_i/rst_i      : clock, synchronous active-high reset
//   satp_i, flush_i  : translation CSR, walk abort
//   miss_*           : miss request from ITLB (accepted only when idle)
//   mem_*            : single-outstanding PTE read port
//   refill_*         : one-cycle refill pulse with registered VPN/PTE/size
//   fault_*          : one-cycle fault pulse, cause 0 = IPF, 1 = IAF
//   busy_o           : walk in progress
module itlb_ptw_ctrl
    import mms_pkg::*;
#(
    parameter int PA_W = SV32_PA_W,
    parameter int XLEN = MXLEN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [XLEN-1:0]       satp_i,
    input  logic                  flush_i,
    input  logic                  miss_valid_i,
    input  logic [SV32_VPN_W-1:0] miss_vpn_i,
    output logic                  miss_ready_o,
    output logic                  mem_req_o,
    output logic [PA_W-1:0]       mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [XLEN-1:0]       mem_rdata_i,
    input  logic                  mem_err_i,
    output logic                  refill_valid_o,
    output logic [SV32_VPN_W-1:0] refill_vpn_o,
    output logic [XLEN-1:0]       refill_pte_o,
    output logic                  refill_super_o,
    output logic                  fault_valid_o,
    output logic                  fault_cause_o,
    output logic                  busy_o
);

    ptw_state_e state, nxt;

    satp_t satp;
    pte_t  rd_pte;
    assign satp   = satp_t'(satp_i);
    assign rd_pte = pte_t'(mem_rdata_i);

    // ASID only matters to the TLB tags
    logic unused_asid;
    assign unused_asid = ^satp.asid;

    logic [SV32_VPN_W-1:0] vpn_q, vpn_d;
    logic [PA_W-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]       pte_q, pte_d;
    logic                  super_q, super_d;
    logic                  fault_q, fault_d;
    logic                  cause_q, cause_d;

    logic pte_leaf, pte_fault;

    itlb_ptw_pte_check u_pte_check (
        .pte   (rd_pte),
        .is_l1 (state == L1_WAIT),
        .leaf  (pte_leaf),
        .fault (pte_fault)
    );

    // satp.mode is only consulted at acceptance; the path taken (DONE vs
    // L1_REQ) carries that decision for the rest of the walk.
    always_comb begin
        nxt     = state;
        vpn_d   = vpn_q;
        addr_d  = addr_q;
        pte_d   = pte_q;
        super_d = super_q;
        fault_d = fault_q;
        cause_d = cause_q;
        case (state)
            IDLE: begin
                if (miss_valid_i && !flush_i) begin
                    vpn_d = miss_vpn_i;
                    if (satp.mode) begin
                        nxt    = L1_REQ;
                        addr_d = {satp.ppn, miss_vpn_i[19:10], 2'b00};
                    end else begin
                        // Bare: identity map, V|R|X|A
                        nxt     = DONE;
                        pte_d   = {2'b00, miss_vpn_i, 10'h04B};
                        super_d = 1'b0;
                        fault_d = 1'b0;
                    end
                end
            end
            L1_REQ, L0_REQ: begin
                // A granted read must still be drained even if flushed
                if (mem_gnt_i)
                    nxt = flush_i ? DRAIN : ((state == L1_REQ) ? L1_WAIT : L0_WAIT);
                else if (flush_i)
                    nxt = IDLE;
            end
            L1_WAIT, L0_WAIT: begin
                if (mem_rvalid_i) begin
                    if (flush_i) begin
                        nxt = IDLE;
                    end else if (mem_err_i) begin
                        nxt     = DONE;
                        fault_d = 1'b1;
                        cause_d = 1'b1;
                    end else if (pte_fault) begin
                        nxt     = DONE;
                        fault_d = 1'b1;
                        cause_d = 1'b0;
                    end else if (pte_leaf) begin
                        nxt     = DONE;
                        fault_d = 1'b0;
                        pte_d   = mem_rdata_i;
                        super_d = (state == L1_WAIT);
                    end else begin
                        // L1 pointer (L0 pointers are flagged by pte_fault)
                        nxt    = L0_REQ;
                        addr_d = {rd_pte.ppn1, rd_pte.ppn0, vpn_q[9:0], 2'b00};
                    end
                end else if (flush_i) begin
                    nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_rvalid_i) nxt = IDLE;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            vpn_q   <= '0;
            addr_q  <= '0;
            pte_q   <= '0;
            super_q <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            state   <= nxt;
            vpn_q   <= vpn_d;
            addr_q  <= addr_d;
            pte_q   <= pte_d;
            super_q <= super_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    assign miss_ready_o   = (state == IDLE);
    assign busy_o         = (state != IDLE);
    assign mem_req_o      = (state == L1_REQ) || (state == L0_REQ);
    assign mem_addr_o     = addr_q;
    // flush in DONE kills the pulse for the aborted walk
    assign refill_valid_o = (state == DONE) && !fault_q && !flush_i;
    assign fault_valid_o  = (state == DONE) &&  fault_q && !flush_i;
    assign fault_cause_o  = cause_q;
    assign refill_vpn_o   = vpn_q;
    assign refill_pte_o   = pte_q;
    assign refill_super_o = super_q;

endmodule
